// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues FP32 ops to the FPU with slot tags, blocks RAW/WAW hazards on in-flight
// destinations, buffers out-of-order results and drains them, lowest slot first, to writeback.
module fpu_issue_ctrl #(
   parameter int SLOTS = 4,
   localparam int TW = $clog2(SLOTS)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          issue_req_i,
   input  logic [4:0]    issue_rd_addr_i,
   input  logic          issue_rd_bank_i,
   input  logic [14:0]   rs_addr_i,
   input  logic [2:0]    rs_bank_i,
   input  logic [2:0]    rs_used_i,
   input  logic          flush_i,
   output logic          fpu_req_o,
   input  logic          fpu_gnt_i,
   output logic [TW-1:0] fpu_tag_o,
   input  logic          fpu_rvalid_i,
   input  logic [TW-1:0] fpu_tag_i,
   input  logic [31:0]   fpu_result_i,
   input  logic [4:0]    fpu_flags_i,
   output logic          wb_valid_o,
   input  logic          wb_ready_i,
   output logic [4:0]    wb_addr_o,
   output logic          wb_bank_o,
   output logic [31:0]   wb_data_o,
   output logic [4:0]    wb_flags_o,
   output logic          stall_id_o,
   output logic          busy_o,
   output logic          protocol_err_o
);
   logic [SLOTS-1:0]        valid_q, valid_d, done_q, done_d, bank_q, bank_d;
   logic [SLOTS-1:0][4:0]   rd_q, rd_d, flags_q, flags_d;
   logic [SLOTS-1:0][31:0]  res_q, res_d;
   logic                    err_q, err_d;
   logic [TW-1:0]           alloc_idx, wb_idx;
   logic                    free, raw_hz, waw_hz, fire, wb_any;

   // Descending scan so the lowest matching index wins; x0 on the X bank never aliases.
   always_comb begin
      free = 1'b0;
      alloc_idx = '0;
      wb_any = 1'b0;
      wb_idx = '0;
      raw_hz = 1'b0;
      waw_hz = 1'b0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
         if (!valid_q[s]) begin
            free = 1'b1;
            alloc_idx = TW'(s);
         end
         if (valid_q[s] && done_q[s]) begin
            wb_any = 1'b1;
            wb_idx = TW'(s);
         end
         for (int i = 0; i < 3; i++)
            if (rs_used_i[i] && valid_q[s] && bank_q[s] == rs_bank_i[i] &&
                rd_q[s] == rs_addr_i[5*i +: 5] && (rs_bank_i[i] || rs_addr_i[5*i +: 5] != 5'd0))
               raw_hz = 1'b1;
         if (issue_req_i && valid_q[s] && bank_q[s] == issue_rd_bank_i &&
             rd_q[s] == issue_rd_addr_i && (issue_rd_bank_i || issue_rd_addr_i != 5'd0))
            waw_hz = 1'b1;
      end
   end

   assign fpu_req_o      = issue_req_i & free & ~raw_hz & ~waw_hz & ~flush_i;
   assign fpu_tag_o      = alloc_idx;
   assign fire           = fpu_req_o & fpu_gnt_i;
   assign stall_id_o     = ~flush_i & (raw_hz | (issue_req_i & ~fire));
   assign wb_valid_o     = wb_any;
   assign wb_addr_o      = wb_any ? rd_q[wb_idx] : 5'd0;
   assign wb_bank_o      = wb_any ? bank_q[wb_idx] : 1'b0;
   assign wb_data_o      = wb_any ? res_q[wb_idx] : 32'd0;
   assign wb_flags_o     = wb_any ? flags_q[wb_idx] : 5'd0;
   assign busy_o         = |valid_q;
   assign protocol_err_o = err_q;

   // Allocation only targets slots invalid in registered state, so it never collides with a drain.
   always_comb begin
      valid_d = valid_q;
      done_d = done_q;
      bank_d = bank_q;
      rd_d = rd_q;
      flags_d = flags_q;
      res_d = res_q;
      err_d = err_q;
      if (wb_any && wb_ready_i)
         valid_d[wb_idx] = 1'b0;
      if (fire) begin
         valid_d[alloc_idx] = 1'b1;
         done_d[alloc_idx] = 1'b0;
         rd_d[alloc_idx] = issue_rd_addr_i;
         bank_d[alloc_idx] = issue_rd_bank_i;
      end
      if (fpu_rvalid_i) begin
         if (valid_q[fpu_tag_i] && !done_q[fpu_tag_i]) begin
            done_d[fpu_tag_i] = 1'b1;
            res_d[fpu_tag_i] = fpu_result_i;
            flags_d[fpu_tag_i] = fpu_flags_i;
         end else
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         done_q <= '0;
         bank_q <= '0;
         rd_q <= '0;
         flags_q <= '0;
         res_q <= '0;
         err_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         done_q <= done_d;
         bank_q <= bank_d;
         rd_q <= rd_d;
         flags_q <= flags_d;
         res_q <= res_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed stimulus; expected writebacks queued at result time and
// checked by an independent monitor on each accepted writeback.
module tb_fpu_issue_ctrl;
   localparam int SLOTS = 4;
   localparam int TW = 2;

   logic          clk_i = 1'b0, rst_n_i;
   logic          issue_req_i, issue_rd_bank_i, flush_i, fpu_gnt_i, fpu_rvalid_i, wb_ready_i;
   logic [4:0]    issue_rd_addr_i, fpu_flags_i;
   logic [14:0]   rs_addr_i;
   logic [2:0]    rs_bank_i, rs_used_i;
   logic [TW-1:0] fpu_tag_i, fpu_tag_o;
   logic [31:0]   fpu_result_i, wb_data_o;
   logic          fpu_req_o, wb_valid_o, wb_bank_o, stall_id_o, busy_o, protocol_err_o;
   logic [4:0]    wb_addr_o, wb_flags_o;

   int total = 0, bad = 0;
   logic [42:0] exp_q[$];

   fpu_issue_ctrl #(.SLOTS(SLOTS)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .issue_req_i(issue_req_i),
      .issue_rd_addr_i(issue_rd_addr_i), .issue_rd_bank_i(issue_rd_bank_i),
      .rs_addr_i(rs_addr_i), .rs_bank_i(rs_bank_i), .rs_used_i(rs_used_i), .flush_i(flush_i),
      .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i), .fpu_tag_o(fpu_tag_o),
      .fpu_rvalid_i(fpu_rvalid_i), .fpu_tag_i(fpu_tag_i), .fpu_result_i(fpu_result_i),
      .fpu_flags_i(fpu_flags_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_addr_o(wb_addr_o), .wb_bank_o(wb_bank_o), .wb_data_o(wb_data_o),
      .wb_flags_o(wb_flags_o), .stall_id_o(stall_id_o), .busy_o(busy_o),
      .protocol_err_o(protocol_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic b, input logic [31:0] d, input logic [4:0] f);
      exp_q.push_back({a, b, d, f});
   endtask

   always @(negedge clk_i) begin
      if (rst_n_i && wb_valid_o && wb_ready_i) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got %0h with nothing expected",
                     {wb_addr_o, wb_bank_o, wb_data_o, wb_flags_o});
         end else
            chk("wb", {wb_addr_o, wb_bank_o, wb_data_o, wb_flags_o}, exp_q.pop_front());
      end
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic probe;
      @(negedge clk_i);
   endtask

   task automatic issue(input logic [4:0] rd, input logic bank);
      issue_req_i = 1'b1;
      issue_rd_addr_i = rd;
      issue_rd_bank_i = bank;
   endtask

   task automatic res(input logic [TW-1:0] t, input logic [31:0] d, input logic [4:0] f);
      fpu_rvalid_i = 1'b1;
      fpu_tag_i = t;
      fpu_result_i = d;
      fpu_flags_i = f;
   endtask

   initial begin
      rst_n_i = 1'b0;
      issue_req_i = 1'b0; issue_rd_addr_i = '0; issue_rd_bank_i = 1'b0;
      rs_addr_i = '0; rs_bank_i = '0; rs_used_i = '0; flush_i = 1'b0;
      fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b0; fpu_tag_i = '0; fpu_result_i = '0; fpu_flags_i = '0;
      wb_ready_i = 1'b0;
      #2;
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", protocol_err_o, 0);
      chk("rst_stall", stall_id_o, 0);
      chk("rst_wb_data", {wb_addr_o, wb_data_o, wb_flags_o}, 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      tick;

      // basic issue / complete / writeback
      issue(5'd3, 1'b1);
      probe; chk("t1_req", fpu_req_o, 1); chk("t1_tag", fpu_tag_o, 0); chk("t1_stall", stall_id_o, 0);
      tick; issue_req_i = 1'b0;
      res(0, 32'h3F80_0000, 5'b00001); push(5'd3, 1'b1, 32'h3F80_0000, 5'b00001);
      probe; chk("t1_busy", busy_o, 1); chk("t1_no_bypass", wb_valid_o, 0);
      tick; fpu_rvalid_i = 1'b0;
      probe; chk("t1_wb_valid", wb_valid_o, 1); chk("t1_wb_addr", wb_addr_o, 3);
      tick; wb_ready_i = 1'b1;
      tick;
      probe; chk("t1_idle_busy", busy_o, 0); chk("t1_idle_wb", wb_valid_o, 0);
      tick;

      // out-of-order completion, slot reuse
      issue(5'd1, 1'b1);
      probe; chk("t2_req0", fpu_req_o, 1); chk("t2_tag0", fpu_tag_o, 0);
      tick; issue(5'd2, 1'b1);
      probe; chk("t2_req1", fpu_req_o, 1); chk("t2_tag1", fpu_tag_o, 1);
      tick; issue_req_i = 1'b0;
      res(1, 32'h4000_0000, 5'b00000); push(5'd2, 1'b1, 32'h4000_0000, 5'b00000);
      tick;
      res(0, 32'h3FC0_0000, 5'b00010); push(5'd1, 1'b1, 32'h3FC0_0000, 5'b00010);
      probe; chk("t2_first_wb", wb_addr_o, 2);
      tick; fpu_rvalid_i = 1'b0; issue(5'd4, 1'b1);
      probe; chk("t2_second_wb", wb_addr_o, 1); chk("t2_reuse_req", fpu_req_o, 1);
      chk("t2_reuse_tag", fpu_tag_o, 1);
      tick; issue_req_i = 1'b0;
      res(1, 32'h4080_0000, 5'b10000); push(5'd4, 1'b1, 32'h4080_0000, 5'b10000);
      tick; fpu_rvalid_i = 1'b0;
      tick; tick;
      probe; chk("t2_busy", busy_o, 0);
      tick;

      // capacity
      wb_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         issue(5'(10 + k), 1'b1);
         probe; chk("t3_fill_req", fpu_req_o, 1); chk("t3_fill_tag", fpu_tag_o, k);
         tick;
      end
      issue(5'd14, 1'b1);
      probe; chk("t3_full_req", fpu_req_o, 0); chk("t3_full_stall", stall_id_o, 1);
      tick; issue_req_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         res(TW'(k), 32'h4100_0000 + k, 5'(k)); push(5'(10 + k), 1'b1, 32'h4100_0000 + k, 5'(k));
         tick;
      end
      fpu_rvalid_i = 1'b0; issue(5'd14, 1'b1);
      probe; chk("t3_held_wb", wb_valid_o, 1); chk("t3_held_addr", wb_addr_o, 10);
      chk("t3_held_stall", stall_id_o, 1);
      tick; wb_ready_i = 1'b1;
      probe; chk("t3_no_same_cycle_realloc", fpu_req_o, 0); chk("t3_stall_on_free", stall_id_o, 1);
      tick; wb_ready_i = 1'b0;
      probe; chk("t3_resume_req", fpu_req_o, 1); chk("t3_resume_tag", fpu_tag_o, 0);
      chk("t3_resume_stall", stall_id_o, 0);
      tick; issue_req_i = 1'b0; wb_ready_i = 1'b1;
      tick; tick; tick;
      res(0, 32'h4160_0000, 5'b00100); push(5'd14, 1'b1, 32'h4160_0000, 5'b00100);
      tick; fpu_rvalid_i = 1'b0;
      tick; tick;
      probe; chk("t3_busy", busy_o, 0);
      tick;

      // hazards
      issue(5'd5, 1'b1);
      probe; chk("t4_req", fpu_req_o, 1); chk("t4_tag", fpu_tag_o, 0);
      tick; issue_req_i = 1'b0;
      rs_addr_i = {5'd0, 5'd5, 5'd0}; rs_used_i = 3'b010; rs_bank_i = 3'b010;
      probe; chk("t4_raw_f5", stall_id_o, 1);
      tick; rs_bank_i = 3'b000;
      probe; chk("t4_x5_no_raw", stall_id_o, 0);
      tick; rs_used_i = 3'b000; issue(5'd5, 1'b1);
      probe; chk("t4_waw_req", fpu_req_o, 0); chk("t4_waw_stall", stall_id_o, 1);
      tick; issue(5'd0, 1'b0);
      probe; chk("t4_x0_req", fpu_req_o, 1); chk("t4_x0_tag", fpu_tag_o, 1);
      tick; rs_addr_i = '0; rs_used_i = 3'b001; rs_bank_i = 3'b000;
      probe; chk("t4_x0_again_req", fpu_req_o, 1); chk("t4_x0_again_stall", stall_id_o, 0);
      chk("t4_x0_again_tag", fpu_tag_o, 2);
      tick; issue_req_i = 1'b0;
      rs_addr_i = {5'd0, 5'd5, 5'd0}; rs_used_i = 3'b010; rs_bank_i = 3'b010;
      res(0, 32'h40A0_0000, 5'b00000); push(5'd5, 1'b1, 32'h40A0_0000, 5'b00000);
      probe; chk("t4_raw_inflight", stall_id_o, 1);
      tick; fpu_rvalid_i = 1'b0;
      probe; chk("t4_wb_f5", wb_addr_o, 5); chk("t4_raw_until_wb", stall_id_o, 1);
      tick;
      probe; chk("t4_raw_released", stall_id_o, 0);
      tick; rs_used_i = 3'b000;
      res(1, 32'h0000_1234, 5'b00000); push(5'd0, 1'b0, 32'h0000_1234, 5'b00000);
      tick;
      res(2, 32'h0000_5678, 5'b00001); push(5'd0, 1'b0, 32'h0000_5678, 5'b00001);
      tick; fpu_rvalid_i = 1'b0;
      tick; tick;
      probe; chk("t4_busy", busy_o, 0);
      tick;

      // protocol error
      issue(5'd7, 1'b1);
      probe; chk("t5_tag", fpu_tag_o, 0);
      tick; issue_req_i = 1'b0;
      res(2, 32'hDEAD_BEEF, 5'b11111);
      probe; chk("t5_err_before", protocol_err_o, 0);
      tick; fpu_rvalid_i = 1'b0;
      probe; chk("t5_err", protocol_err_o, 1); chk("t5_busy", busy_o, 1);
      chk("t5_no_wb", wb_valid_o, 0);
      tick;
      res(0, 32'h40E0_0000, 5'b00001); push(5'd7, 1'b1, 32'h40E0_0000, 5'b00001);
      tick; fpu_rvalid_i = 1'b0;
      probe; chk("t5_err_sticky", protocol_err_o, 1);
      tick;
      probe; chk("t5_busy_after", busy_o, 0);
      tick;

      // flush, then async reset mid-flight
      issue(5'd8, 1'b1); flush_i = 1'b1;
      probe; chk("t6_flush_req", fpu_req_o, 0); chk("t6_flush_stall", stall_id_o, 0);
      tick; issue_req_i = 1'b0; flush_i = 1'b0;
      probe; chk("t6_flush_no_alloc", busy_o, 0);
      tick; wb_ready_i = 1'b0; issue(5'd9, 1'b1);
      tick; issue(5'd10, 1'b1);
      tick; issue_req_i = 1'b0; res(0, 32'h4110_0000, 5'b00000);
      tick; fpu_rvalid_i = 1'b0;
      probe; chk("t6_pre_wb", wb_valid_o, 1); chk("t6_pre_busy", busy_o, 1);
      #2 rst_n_i = 1'b0;
      #1;
      chk("t6_rst_wb_valid", wb_valid_o, 0);
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_err", protocol_err_o, 0);
      chk("t6_rst_wb_data", {wb_addr_o, wb_bank_o, wb_data_o, wb_flags_o}, 0);
      chk("t6_rst_stall", stall_id_o, 0);
      #3 rst_n_i = 1'b1;
      tick; tick;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
